// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST session controller and its MISR.
package bist_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StRun,
      StDrain,
      StCompare,
      StDone
   } state_e;

   localparam logic [7:0] LfsrSeed    = 8'h01;
   localparam logic [7:0] DefaultPoly = 8'h32;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting CUT responses into a signature.
module bist_misr
   import bist_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DefaultPoly)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] resp,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] taps;
   logic [WIDTH-1:0] sig_next;

   // Bit 0 always takes the feedback regardless of POLY[0].
   assign taps     = POLY | WIDTH'(1);
   assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ ({WIDTH{sig[WIDTH-1]}} & taps) ^ resp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig <= '0;
      end else if (clear) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/bist_controller.sv
// Sequences one BIST session: LFSR release, response compaction, signature compare.
module bist_controller
   import bist_pkg::*;
#(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      NUM_PATTERNS = 255,
   parameter int unsigned      CUT_LATENCY  = 0,
   parameter logic [WIDTH-1:0] POLY         = WIDTH'(DefaultPoly),
   parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [WIDTH-1:0]                      lfsr_q,
   input  logic [WIDTH-1:0]                      cut_resp,
   output logic                                  lfsr_reset,
   output logic                                  test_mode,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic                                  fail,
   output logic [WIDTH-1:0]                      signature,
   output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_cnt
);

   localparam int unsigned     CW        = $clog2(NUM_PATTERNS + 1);
   localparam logic [CW-1:0]   MaxCnt    = CW'(NUM_PATTERNS);
   localparam logic [CW-1:0]   LastCnt   = CW'(NUM_PATTERNS - 1);
   localparam logic [1:0]      LastDrain = 2'((CUT_LATENCY == 0) ? 0 : CUT_LATENCY - 1);

   state_e     state;
   logic [1:0] drain_cnt;
   logic       run;
   logic       valid;
   logic       unused_lfsr;

   assign run         = (state == StRun);
   // lfsr_q is for external monitoring only; the pattern reaches the CUT outside this block.
   assign unused_lfsr = ^lfsr_q;

   if (CUT_LATENCY == 0) begin : g_nolat
      assign valid = run;
   end else begin : g_lat
      logic [CUT_LATENCY-1:0] pipe;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            pipe <= '0;
         end else if (abort) begin
            pipe <= '0;
         end else begin
            pipe <= CUT_LATENCY'({pipe, run});
         end
      end
      assign valid = pipe[CUT_LATENCY-1];
   end

   bist_misr #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr (
      .clk   (clk),
      .reset (reset),
      .clear (state == StInit && !abort),
      .en    (valid && !abort),
      .resp  (cut_resp),
      .sig   (signature)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= StIdle;
         lfsr_reset  <= 1'b1;
         test_mode   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         pattern_cnt <= '0;
         drain_cnt   <= '0;
      end else if (abort) begin
         state      <= StIdle;
         lfsr_reset <= 1'b1;
         test_mode  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state <= StInit;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  pass  <= 1'b0;
                  fail  <= 1'b0;
               end
            end
            StInit: begin
               state       <= StRun;
               pattern_cnt <= '0;
               lfsr_reset  <= 1'b0;
               test_mode   <= 1'b1;
            end
            StRun: begin
               if (pattern_cnt != MaxCnt) pattern_cnt <= pattern_cnt + 1'b1;
               if (pattern_cnt == LastCnt) begin
                  lfsr_reset <= 1'b1;
                  drain_cnt  <= '0;
                  if (CUT_LATENCY == 0) begin
                     state     <= StCompare;
                     test_mode <= 1'b0;
                  end else begin
                     state <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (drain_cnt == LastDrain) begin
                  state     <= StCompare;
                  test_mode <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            StCompare: begin
               state <= StDone;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (signature == GOLDEN_SIG);
               fail  <= (signature != GOLDEN_SIG);
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench: four controller instances with different pattern counts and CUT latencies.
module tb_bist_controller;
   import bist_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [3:0] start, abort;
   wire  [3:0] lfsr_rst, test_mode, busy, done, pass, fail;
   wire  [7:0] sig [4];
   wire  [7:0] cnt_a;
   wire  [0:0] cnt_b;
   wire  [3:0] cnt_c, cnt_d;
   logic [7:0] lfsr [4];
   logic [7:0] d1, d2;

   logic [7:0] exp_pat [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h33};

   // Galois step shared by the external LFSR model and the signature model (taps 0x32, bit0 fed).
   function automatic logic [7:0] step(input logic [7:0] m, input logic [7:0] r);
      return {m[6:0], 1'b0} ^ ({8{m[7]}} & 8'h33) ^ r;
   endfunction

   function automatic logic [7:0] model_sig(input int n);
      logic [7:0] p;
      logic [7:0] m;
      p = LfsrSeed;
      m = 8'h00;
      for (int j = 0; j < n; j++) begin
         m = step(m, p);
         p = step(p, 8'h00);
      end
      return m;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) lfsr[i] <= lfsr_rst[i] ? LfsrSeed : step(lfsr[i], 8'h00);
      d1 <= lfsr[3];
      d2 <= d1;
   end

   bist_controller #(.NUM_PATTERNS(255), .CUT_LATENCY(0), .GOLDEN_SIG(8'h00)) u_a (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .lfsr_q(lfsr[0]),
      .cut_resp(8'h00), .lfsr_reset(lfsr_rst[0]), .test_mode(test_mode[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .fail(fail[0]), .signature(sig[0]), .pattern_cnt(cnt_a));

   bist_controller #(.NUM_PATTERNS(1), .CUT_LATENCY(0), .GOLDEN_SIG(8'h00)) u_b (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .lfsr_q(lfsr[1]),
      .cut_resp(lfsr[1]), .lfsr_reset(lfsr_rst[1]), .test_mode(test_mode[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .fail(fail[1]), .signature(sig[1]), .pattern_cnt(cnt_b));

   bist_controller #(.NUM_PATTERNS(9), .CUT_LATENCY(0), .GOLDEN_SIG(8'h00)) u_c (
      .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]), .lfsr_q(lfsr[2]),
      .cut_resp(lfsr[2]), .lfsr_reset(lfsr_rst[2]), .test_mode(test_mode[2]), .busy(busy[2]),
      .done(done[2]), .pass(pass[2]), .fail(fail[2]), .signature(sig[2]), .pattern_cnt(cnt_c));

   bist_controller #(.NUM_PATTERNS(9), .CUT_LATENCY(2), .GOLDEN_SIG(8'h00)) u_d (
      .clk(clk), .reset(reset), .start(start[3]), .abort(abort[3]), .lfsr_q(lfsr[3]),
      .cut_resp(d2), .lfsr_reset(lfsr_rst[3]), .test_mode(test_mode[3]), .busy(busy[3]),
      .done(done[3]), .pass(pass[3]), .fail(fail[3]), .signature(sig[3]), .pattern_cnt(cnt_d));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start(input logic [3:0] which);
      start = which;
      tick();
      start = '0;
   endtask

   // Waits for done on one instance, counting busy cycles; gives up after limit cycles.
   task automatic wait_done(input int idx, input int limit, output int nbusy);
      int guard;
      nbusy = 0;
      guard = 0;
      while (!done[idx] && guard < limit) begin
         if (busy[idx]) nbusy++;
         guard++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = '0;
      abort = '0;
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({lfsr_rst[i], test_mode[i], busy[i], done[i], pass[i], fail[i]} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags[%0d]: got %b want 100000", i,
                     {lfsr_rst[i], test_mode[i], busy[i], done[i], pass[i], fail[i]});
         end
         total++;
         if (sig[i] !== 8'h00) begin
            bad++;
            $display("FAIL reset_sig[%0d]: got %h want 00", i, sig[i]);
         end
      end
      total++;
      if (cnt_a !== 8'd0 || cnt_c !== 4'd0) begin
         bad++;
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_c);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_full_zero();
      int nb;
      pulse_start(4'b0001);
      wait_done(0, 400, nb);
      total++;
      if (done[0] !== 1'b1) begin
         bad++;
         $display("FAIL full_done: got %b want 1", done[0]);
      end
      total++;
      if (nb != 257) begin
         bad++;
         $display("FAIL full_busy_cycles: got %0d want 257", nb);
      end
      total++;
      if ({pass[0], fail[0], busy[0], lfsr_rst[0]} !== 4'b1001 || sig[0] !== 8'h00) begin
         bad++;
         $display("FAIL full_result: got pfbl=%b sig=%h want 1001 sig=00",
                  {pass[0], fail[0], busy[0], lfsr_rst[0]}, sig[0]);
      end
      total++;
      if (cnt_a !== 8'd255) begin
         bad++;
         $display("FAIL full_cnt: got %0d want 255", cnt_a);
      end
   endtask

   task automatic test_single();
      int nb;
      pulse_start(4'b0010);
      wait_done(1, 20, nb);
      total++;
      if (done[1] !== 1'b1 || nb != 3) begin
         bad++;
         $display("FAIL single_done: got done=%b busy_cycles=%0d want 1/3", done[1], nb);
      end
      total++;
      if (sig[1] !== 8'h01) begin
         bad++;
         $display("FAIL single_sig: got %h want 01", sig[1]);
      end
      total++;
      if ({pass[1], fail[1]} !== 2'b01 || cnt_b !== 1'b1) begin
         bad++;
         $display("FAIL single_result: got pf=%b cnt=%0d want 01/1", {pass[1], fail[1]}, cnt_b);
      end
   endtask

   task automatic test_sequence_latency();
      logic [7:0] seen [9];
      logic [7:0] m;
      int k;
      int drains;
      int guard;
      k = 0;
      drains = 0;
      guard = 0;
      m = 8'h00;
      for (int j = 0; j < 9; j++) m = step(m, exp_pat[j]);
      pulse_start(4'b1100);
      while (!(done[2] && done[3]) && guard < 100) begin
         if (busy[2] && test_mode[2] && !lfsr_rst[2]) begin
            if (k < 9) seen[k] = lfsr[2];
            k++;
         end
         if (busy[3] && test_mode[3] && lfsr_rst[3]) drains++;
         guard++;
         tick();
      end
      total++;
      if (k != 9) begin
         bad++;
         $display("FAIL seq_run_cycles: got %0d want 9", k);
      end
      for (int j = 0; j < 9 && j < k; j++) begin
         total++;
         if (seen[j] !== exp_pat[j]) begin
            bad++;
            $display("FAIL seq_pattern[%0d]: got %h want %h", j, seen[j], exp_pat[j]);
         end
      end
      total++;
      if (sig[2] !== m) begin
         bad++;
         $display("FAIL seq_sig: got %h want %h", sig[2], m);
      end
      total++;
      if ({pass[2], fail[2]} !== {m == 8'h00, m != 8'h00} || cnt_c !== 4'd9) begin
         bad++;
         $display("FAIL seq_result: got pf=%b cnt=%0d want %b/9", {pass[2], fail[2]}, cnt_c,
                  {m == 8'h00, m != 8'h00});
      end
      total++;
      if (sig[3] !== m || done[3] !== 1'b1) begin
         bad++;
         $display("FAIL lat2_sig: got %h done=%b want %h done=1", sig[3], done[3], m);
      end
      total++;
      if (drains != 2) begin
         bad++;
         $display("FAIL lat2_drain_cycles: got %0d want 2", drains);
      end
   endtask

   task automatic test_back_to_back();
      int nb;
      pulse_start(4'b0100);
      total++;
      if ({busy[2], done[2], pass[2], fail[2]} !== 4'b1000) begin
         bad++;
         $display("FAIL b2b_restart: got bdpf=%b want 1000", {busy[2], done[2], pass[2], fail[2]});
      end
      wait_done(2, 50, nb);
      total++;
      if (done[2] !== 1'b1 || nb != 11 || sig[2] !== model_sig(9)) begin
         bad++;
         $display("FAIL b2b_session: got done=%b busy=%0d sig=%h want 1/11/%h", done[2], nb,
                  sig[2], model_sig(9));
      end
   endtask

   task automatic test_start_busy();
      int nb;
      pulse_start(4'b0100);
      repeat (3) tick();
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      total++;
      if (cnt_c !== 4'd3 || busy[2] !== 1'b1 || lfsr_rst[2] !== 1'b0) begin
         bad++;
         $display("FAIL start_busy_ignored: got cnt=%0d busy=%b lr=%b want 3/1/0", cnt_c,
                  busy[2], lfsr_rst[2]);
      end
      wait_done(2, 50, nb);
      total++;
      if (done[2] !== 1'b1 || sig[2] !== model_sig(9) || cnt_c !== 4'd9) begin
         bad++;
         $display("FAIL start_busy_session: got done=%b sig=%h cnt=%0d want 1/%h/9", done[2],
                  sig[2], cnt_c, model_sig(9));
      end
   endtask

   task automatic test_abort();
      pulse_start(4'b0100);
      repeat (6) tick();
      total++;
      if (cnt_c !== 4'd5 || lfsr[2] !== 8'h20) begin
         bad++;
         $display("FAIL abort_setup: got cnt=%0d lfsr=%h want 5/20", cnt_c, lfsr[2]);
      end
      abort[2] = 1'b1;
      start[2] = 1'b1;
      tick();
      abort[2] = 1'b0;
      start[2] = 1'b0;
      total++;
      if ({busy[2], done[2], pass[2], fail[2], lfsr_rst[2], test_mode[2]} !== 6'b000010) begin
         bad++;
         $display("FAIL abort_state: got bdpflt=%b want 000010",
                  {busy[2], done[2], pass[2], fail[2], lfsr_rst[2], test_mode[2]});
      end
      total++;
      if (cnt_c !== 4'd5) begin
         bad++;
         $display("FAIL abort_cnt: got %0d want 5", cnt_c);
      end
      repeat (3) tick();
      total++;
      if (busy[2] !== 1'b0 || cnt_c !== 4'd5) begin
         bad++;
         $display("FAIL abort_idle_hold: got busy=%b cnt=%0d want 0/5", busy[2], cnt_c);
      end
   endtask

   task automatic test_reset_mid();
      int nb;
      pulse_start(4'b0100);
      repeat (4) tick();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({lfsr_rst[2], test_mode[2], busy[2], done[2]} !== 4'b1000 || sig[2] !== 8'h00 ||
          cnt_c !== 4'd0) begin
         bad++;
         $display("FAIL reset_mid: got ltbd=%b sig=%h cnt=%0d want 1000/00/0",
                  {lfsr_rst[2], test_mode[2], busy[2], done[2]}, sig[2], cnt_c);
      end
      tick();
      reset = 1'b1;
      tick();
      pulse_start(4'b0100);
      wait_done(2, 50, nb);
      total++;
      if (done[2] !== 1'b1 || sig[2] !== model_sig(9) || fail[2] !== (model_sig(9) != 8'h00)) begin
         bad++;
         $display("FAIL reset_mid_session: got done=%b sig=%h fail=%b want 1/%h", done[2],
                  sig[2], fail[2], model_sig(9));
      end
   endtask

   initial begin
      test_reset();
      test_full_zero();
      test_single();
      test_sequence_latency();
      test_back_to_back();
      test_start_busy();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
